// File: rtl/iob_ibex_arb_pkg.sv
// Shared types for the Ibex fetch/LSU bus arbiter: requester IDs, the all-ones byte-enable
// constant and the request record for the default 32-bit build.
package iob_ibex_arb_pkg;

    typedef enum logic {
        ARB_SRC_INSTR = 1'b0,
        ARB_SRC_DATA  = 1'b1
    } arb_src_e;

    localparam int unsigned ARB_ADDR_W = 32;
    localparam int unsigned ARB_DATA_W = 32;

    localparam logic [ARB_DATA_W/8-1:0] BE_ALL = '1;

    typedef struct packed {
        logic                    we;
        logic [ARB_DATA_W/8-1:0] be;
        logic [ARB_ADDR_W-3:0]   addr;
        logic [ARB_DATA_W-1:0]   wdata;
    } arb_req_t;

    function automatic arb_src_e arb_other(input arb_src_e src);
        return (src == ARB_SRC_INSTR) ? ARB_SRC_DATA : ARB_SRC_INSTR;
    endfunction

endpackage

// File: rtl/iob_ibex_arb_idfifo.sv
// In-order FIFO of requester IDs, one entry per granted-but-unanswered transaction.
// A push and a pop in the same cycle are both honoured, including when the FIFO is full.
module iob_ibex_arb_idfifo
    import iob_ibex_arb_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  arb_src_e         push_id_i,
    input  logic             pop_i,
    output arb_src_e         head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    arb_src_e         mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign full_o  = (count_o == CNT_W'(DEPTH));
    assign empty_o = (count_o == '0);
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);
    assign head_o  = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_id_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
        end else begin
            if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
            if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push_ok, pop_ok})
                2'b10:   count_o <= count_o + 1'b1;
                2'b01:   count_o <= count_o - 1'b1;
                default: count_o <= count_o;
            endcase
        end
    end

endmodule

// File: rtl/iob_ibex_bus_arbiter.sv
// Merges Ibex fetch and LSU req/gnt/rvalid streams onto one master port and routes in-order
// responses back. Define IOB_IBEX_ARB_RR_EN for round-robin; otherwise LSU has fixed priority.
module iob_ibex_bus_arbiter
    import iob_ibex_arb_pkg::*;
#(
    parameter  int unsigned ADDR_W  = 32,
    parameter  int unsigned DATA_W  = 32,
    parameter  int unsigned MAX_OUT = 2,
    localparam int unsigned CNT_W   = $clog2(MAX_OUT + 1)
) (
    input  logic                clk_i,
    input  logic                cke_i,
    input  logic                rst_i,
    input  logic                instr_req_i,
    input  logic [ADDR_W-3:0]   instr_addr_i,
    output logic                instr_gnt_o,
    output logic                instr_rvalid_o,
    output logic [DATA_W-1:0]   instr_rdata_o,
    output logic                instr_err_o,
    input  logic                data_req_i,
    input  logic                data_we_i,
    input  logic [DATA_W/8-1:0] data_be_i,
    input  logic [ADDR_W-3:0]   data_addr_i,
    input  logic [DATA_W-1:0]   data_wdata_i,
    output logic                data_gnt_o,
    output logic                data_rvalid_o,
    output logic [DATA_W-1:0]   data_rdata_o,
    output logic                data_err_o,
    output logic                m_req_o,
    output logic                m_we_o,
    output logic [DATA_W/8-1:0] m_be_o,
    output logic [ADDR_W-3:0]   m_addr_o,
    output logic [DATA_W-1:0]   m_wdata_o,
    input  logic                m_gnt_i,
    input  logic                m_rvalid_i,
    input  logic [DATA_W-1:0]   m_rdata_i,
    input  logic                m_err_i,
    output logic [CNT_W-1:0]    outstanding_o,
    output logic                unexp_rsp_o
);

    arb_src_e win;
    arb_src_e head;
    arb_src_e lock_src_q;
    logic     lock_q;
    logic     have_req;
    logic     fifo_full;
    logic     fifo_empty;
    logic     push;
    logic     pop;
    logic     rsp_instr;
    logic     rsp_data;
`ifdef IOB_IBEX_ARB_RR_EN
    arb_src_e pref_q;
`endif

    // A stalled request stays pinned to its requester so the bridge sees stable fields.
    always_comb begin
        win      = ARB_SRC_DATA;
        have_req = 1'b0;
        if (lock_q) begin
            win      = lock_src_q;
            have_req = (lock_src_q == ARB_SRC_INSTR) ? instr_req_i : data_req_i;
        end else if (instr_req_i && data_req_i) begin
`ifdef IOB_IBEX_ARB_RR_EN
            win = pref_q;
`else
            win = ARB_SRC_DATA;
`endif
            have_req = 1'b1;
        end else if (instr_req_i) begin
            win      = ARB_SRC_INSTR;
            have_req = 1'b1;
        end else if (data_req_i) begin
            win      = ARB_SRC_DATA;
            have_req = 1'b1;
        end
    end

    // A response popping this cycle frees a slot, so a full FIFO can still accept a grant.
    assign pop     = cke_i & ~rst_i & m_rvalid_i & ~fifo_empty;
    assign m_req_o = cke_i & ~rst_i & have_req & (~fifo_full | pop);
    assign push    = m_req_o & m_gnt_i;

    always_comb begin
        m_we_o    = 1'b0;
        m_be_o    = '0;
        m_addr_o  = '0;
        m_wdata_o = '0;
        if (m_req_o) begin
            if (win == ARB_SRC_INSTR) begin
                m_be_o   = '1;
                m_addr_o = instr_addr_i;
            end else begin
                m_we_o    = data_we_i;
                m_be_o    = data_be_i;
                m_addr_o  = data_addr_i;
                m_wdata_o = data_wdata_i;
            end
        end
    end

    assign instr_gnt_o = push & (win == ARB_SRC_INSTR);
    assign data_gnt_o  = push & (win == ARB_SRC_DATA);

    assign rsp_instr      = pop & (head == ARB_SRC_INSTR);
    assign rsp_data       = pop & (head == ARB_SRC_DATA);
    assign instr_rvalid_o = rsp_instr;
    assign instr_rdata_o  = rsp_instr ? m_rdata_i : '0;
    assign instr_err_o    = rsp_instr & m_err_i;
    assign data_rvalid_o  = rsp_data;
    assign data_rdata_o   = rsp_data ? m_rdata_i : '0;
    assign data_err_o     = rsp_data & m_err_i;

    iob_ibex_arb_idfifo #(
        .DEPTH (MAX_OUT)
    ) u_idfifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push_i    (push),
        .push_id_i (win),
        .pop_i     (pop),
        .head_o    (head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (outstanding_o)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_q      <= 1'b0;
            lock_src_q  <= ARB_SRC_INSTR;
            unexp_rsp_o <= 1'b0;
`ifdef IOB_IBEX_ARB_RR_EN
            pref_q      <= ARB_SRC_INSTR;
`endif
        end else if (cke_i) begin
            if (m_req_o && !m_gnt_i) begin
                lock_q     <= 1'b1;
                lock_src_q <= win;
            end else if (push) begin
                lock_q <= 1'b0;
            end
            if (m_rvalid_i && fifo_empty) begin
                unexp_rsp_o <= 1'b1;
            end
`ifdef IOB_IBEX_ARB_RR_EN
            if (push) begin
                pref_q <= arb_other(win);
            end
`endif
        end
    end

endmodule

// File: tb/tb_iob_ibex_bus_arbiter.sv
// Directed bench for iob_ibex_bus_arbiter with a response scoreboard; expectations follow
// IOB_IBEX_ARB_RR_EN when defined.
module tb_iob_ibex_bus_arbiter;

    localparam int          MAX_OUT = 2;
    localparam logic [29:0] IADDR   = 30'h0400_0000;
    localparam logic [29:0] DADDR   = 30'h0000_1234;
    localparam logic [3:0]  DBE     = 4'h3;
    localparam logic [31:0] DWDATA  = 32'hCAFE_F00D;
`ifdef IOB_IBEX_ARB_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        cke_i = 1'b1;
    logic        rst_i = 1'b1;
    logic        instr_req_i = 1'b0;
    logic [29:0] instr_addr_i = IADDR;
    logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
    logic [31:0] instr_rdata_o;
    logic        data_req_i = 1'b0;
    logic        data_we_i = 1'b1;
    logic [3:0]  data_be_i = DBE;
    logic [29:0] data_addr_i = DADDR;
    logic [31:0] data_wdata_i = DWDATA;
    logic        data_gnt_o, data_rvalid_o, data_err_o;
    logic [31:0] data_rdata_o;
    logic        m_req_o, m_we_o;
    logic [3:0]  m_be_o;
    logic [29:0] m_addr_o;
    logic [31:0] m_wdata_o;
    logic        m_gnt_i = 1'b0;
    logic        m_rvalid_i = 1'b0;
    logic [31:0] m_rdata_i = '0;
    logic        m_err_i = 1'b0;
    logic [1:0]  outstanding_o;
    logic        unexp_rsp_o;

    always #5 clk = ~clk;

    iob_ibex_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_OUT(MAX_OUT)) dut (
        .clk_i(clk), .cke_i(cke_i), .rst_i(rst_i),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
        .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
        .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
        .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
        .m_req_o(m_req_o), .m_we_o(m_we_o), .m_be_o(m_be_o), .m_addr_o(m_addr_o),
        .m_wdata_o(m_wdata_o), .m_gnt_i(m_gnt_i), .m_rvalid_i(m_rvalid_i),
        .m_rdata_i(m_rdata_i), .m_err_i(m_err_i),
        .outstanding_o(outstanding_o), .unexp_rsp_o(unexp_rsp_o)
    );

    typedef struct {
        logic        src;   // 0 = instr, 1 = data
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        sb [$];
    int          errors = 0;
    int          checks = 0;
    int          out_m = 0;
    logic        lock_m = 1'b0;
    logic        lock_src_m = 1'b0;
    logic        pref_m = 1'b0;
    logic        unexp_m = 1'b0;
    logic [31:0] next_data = '0;
    logic        next_err = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_i = 1'b1; instr_req_i = 1'b0; data_req_i = 1'b0; m_gnt_i = 1'b0; m_rvalid_i = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_m_req", m_req_o, 0);
        chk("rst_outstanding", outstanding_o, 0);
        chk("rst_unexp", unexp_rsp_o, 0);
        chk("rst_rvalid", {instr_rvalid_o, data_rvalid_o, instr_gnt_o, data_gnt_o}, 0);
        chk("rst_m_fields", {m_we_o, m_be_o, m_addr_o, m_wdata_o}, 0);
        rst_i = 1'b0;
        sb.delete();
        out_m = 0; lock_m = 1'b0; lock_src_m = 1'b0; pref_m = 1'b0; unexp_m = 1'b0;
    endtask

    // One clock of stimulus with checks just after the inputs settle, then model update.
    task automatic step(input logic ireq, input logic dreq, input logic gnt, input logic rv);
        exp_t e;
        logic have, win, can, exp_req, nonempty;
        @(negedge clk);
        instr_req_i = ireq; data_req_i = dreq; m_gnt_i = gnt; m_rvalid_i = rv;
        nonempty = (sb.size() != 0);
        if (rv && nonempty) begin
            m_rdata_i = sb[0].data; m_err_i = sb[0].err;
        end else begin
            m_rdata_i = 32'hDEAD_BEEF; m_err_i = 1'b0;
        end
        #1;
        have = 1'b0; win = 1'b1;
        if (lock_m) begin
            win = lock_src_m; have = win ? dreq : ireq;
        end else if (ireq && dreq) begin
            win = RR_MODE ? pref_m : 1'b1; have = 1'b1;
        end else if (ireq) begin
            win = 1'b0; have = 1'b1;
        end else if (dreq) begin
            win = 1'b1; have = 1'b1;
        end
        can = (out_m < MAX_OUT) || (rv && nonempty);
        exp_req = have && can;
        chk("m_req", m_req_o, exp_req);
        chk("instr_gnt", instr_gnt_o, exp_req && gnt && !win);
        chk("data_gnt", data_gnt_o, exp_req && gnt && win);
        chk("outstanding", outstanding_o, out_m);
        chk("unexp", unexp_rsp_o, unexp_m);
        if (exp_req) begin
            chk("m_addr", m_addr_o, win ? DADDR : IADDR);
            chk("m_be", m_be_o, win ? DBE : 4'hF);
            chk("m_we", m_we_o, win);
            chk("m_wdata", m_wdata_o, win ? DWDATA : 32'h0);
        end else begin
            chk("m_idle", {m_we_o, m_be_o, m_addr_o, m_wdata_o}, 0);
        end
        if (rv && nonempty) begin
            e = sb.pop_front();
            chk("instr_rvalid", instr_rvalid_o, !e.src);
            chk("data_rvalid", data_rvalid_o, e.src);
            chk("rsp_rdata", e.src ? data_rdata_o : instr_rdata_o, e.data);
            chk("rsp_err", e.src ? data_err_o : instr_err_o, e.err);
            chk("other_err", e.src ? instr_err_o : data_err_o, 0);
            out_m--;
        end else begin
            chk("no_rvalid", {instr_rvalid_o, data_rvalid_o}, 0);
            if (rv) unexp_m = 1'b1;
        end
        if (exp_req && gnt) begin
            sb.push_back('{src: win, data: next_data, err: next_err});
            out_m++;
            pref_m = !win;
            lock_m = 1'b0;
        end else if (exp_req) begin
            lock_m = 1'b1; lock_src_m = win;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

    initial begin
        do_reset();

        // fetch alone
        next_data = 32'h0000_0013; next_err = 1'b0;
        step(1, 0, 1, 0);
        step(0, 0, 0, 1);

        // contention with grant always high
        for (int k = 0; k < 4; k++) begin
            next_data = 32'h100 + k;
            step(1, 1, 1, k > 0);
        end
        step(0, 0, 0, 1);

        // lock: data stalled three cycles while fetch rises
        next_data = 32'h0000_0D01;
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(1, 1, 1, 0);
        next_data = 32'h0000_0102;
        step(1, 0, 1, 0);

        // full: blocked, then granted alongside a pop
        next_data = 32'h0000_0D03;
        step(0, 1, 1, 0);
        step(0, 1, 1, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);

        // ordering and error routing
        next_data = 32'h0000_AAAA; next_err = 1'b0;
        step(1, 0, 1, 0);
        next_data = 32'h0000_BBBB; next_err = 1'b1;
        step(0, 1, 1, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);

        // unexpected response after reset, sticky until reset
        do_reset();
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        do_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
